// File: rtl/vision_pkg.sv
// Shared types for the vision streaming stages: pixel beat, edge levels and FSM states.
package vision_pkg;

  localparam int PIX_W = 8;

  localparam logic [PIX_W-1:0] EDGE_ON  = 8'hFF;
  localparam logic [PIX_W-1:0] EDGE_OFF = 8'h00;

  typedef logic [0:0] state_t;
  localparam state_t S_IDLE   = 1'b0;
  localparam state_t S_ACTIVE = 1'b1;

  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic             sof;
    logic             eol;
    logic             eof;
  } pix_beat_t;

endpackage

// File: rtl/edge_binarizer_skid_buffer.sv
// Generic 2-entry valid/ready skid buffer; in_ready is registered so it never
// depends combinationally on out_ready or in_valid.
module stream_skid_buffer #(
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  // Handshake: a beat moves when valid & ready are both high at a rising edge;
  // out_valid/out_data hold steady until accepted, in_ready ignores in_valid.
  T           mem_q [2];
  T           mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       in_ready_q, in_ready_d;
  logic       push, pop;

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid & out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    in_ready_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      in_ready_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];

endmodule

// File: rtl/edge_binarizer.sv
// Thresholds the convolution magnitude stream to 0x00/0xFF, blanks the 1-pixel
// frame border, tags sof/eol/eof and reports the per-frame edge-pixel count.
module edge_binarizer
  import vision_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int W          = PIX_W,
  parameter int CNT_W      = $clog2(IMG_WIDTH*IMG_HEIGHT+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     threshold,
  input  logic             x_valid,
  output logic             x_ready,
  input  logic [W-1:0]     x_data,
  output logic             y_valid,
  input  logic             y_ready,
  output logic [W-1:0]     y_data,
  output logic             y_sof,
  output logic             y_eol,
  output logic             y_eof,
  output logic [CNT_W-1:0] edge_count,
  output logic             count_valid,
  output state_t           dbg_state
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH-1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT-1);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  state_t           state_q, state_d;
  logic [W-1:0]     thr_q, thr_d;
  logic [CNT_W-1:0] acc_q, acc_d, acc_next;
  logic [CNT_W-1:0] edge_count_q, edge_count_d;
  logic             count_valid_q, count_valid_d;
  logic             x_fire, first_col, last_col, first_row, last_row;
  logic             border, pix_edge;
  pix_beat_t        beat_in, beat_out;

  assign x_fire    = x_valid & x_ready;
  assign first_col = (col_q == '0);
  assign last_col  = (col_q == COL_LAST);
  assign first_row = (row_q == '0);
  assign last_row  = (row_q == ROW_LAST);
  assign border    = first_row | last_row | first_col | last_col;
  assign pix_edge  = !border && (x_data >= thr_q);
  assign acc_next  = acc_q + CNT_W'(pix_edge);

  always_comb begin
    beat_in.data = pix_edge ? EDGE_ON : EDGE_OFF;
    beat_in.sof  = first_row & first_col;
    beat_in.eol  = last_col;
    beat_in.eof  = last_row & last_col;
  end

  // The sof pixel is always border, so the stale thr_q it sees never matters.
  always_comb begin
    col_d         = col_q;
    row_d         = row_q;
    state_d       = state_q;
    thr_d         = thr_q;
    acc_d         = acc_q;
    edge_count_d  = edge_count_q;
    count_valid_d = 1'b0;
    if (x_fire) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
      case (state_q)
        S_IDLE: begin
          thr_d   = threshold;
          acc_d   = '0;
          state_d = S_ACTIVE;
        end
        default: begin
          acc_d = acc_next;
          if (last_row && last_col) begin
            edge_count_d  = acc_next;
            count_valid_d = 1'b1;
            state_d       = S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q         <= '0;
      row_q         <= '0;
      state_q       <= S_IDLE;
      thr_q         <= '0;
      acc_q         <= '0;
      edge_count_q  <= '0;
      count_valid_q <= 1'b0;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      state_q       <= state_d;
      thr_q         <= thr_d;
      acc_q         <= acc_d;
      edge_count_q  <= edge_count_d;
      count_valid_q <= count_valid_d;
    end
  end

  stream_skid_buffer #(.T(pix_beat_t)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (x_valid),
    .in_ready  (x_ready),
    .in_data   (beat_in),
    .out_valid (y_valid),
    .out_ready (y_ready),
    .out_data  (beat_out)
  );

  assign y_data      = beat_out.data;
  assign y_sof       = beat_out.sof;
  assign y_eol       = beat_out.eol;
  assign y_eof       = beat_out.eof;
  assign edge_count  = edge_count_q;
  assign count_valid = count_valid_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_edge_binarizer.sv
// Bench for edge_binarizer: a 4x3 instance for the directed and table cases and
// a 40x30 instance for long random frames, both checked against a pixel-rule model.
module tb_edge_binarizer;

  localparam int AW = 4;
  localparam int AH = 3;
  localparam int BW = 40;
  localparam int BH = 30;
  localparam int A_CNT_W = $clog2(AW*AH+1);
  localparam int B_CNT_W = $clog2(BW*BH+1);

  typedef struct {
    logic [7:0] pix;
    logic [7:0] exp_data;
    logic       exp_sof;
    logic       exp_eol;
    logic       exp_eof;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT A (4x3) ----------------
  logic [7:0]         threshold = 8'h00;
  logic               x_valid = 1'b0;
  logic               x_ready;
  logic [7:0]         x_data = 8'h00;
  logic               y_valid;
  logic               y_ready = 1'b1;
  logic [7:0]         y_data;
  logic               y_sof, y_eol, y_eof;
  logic [A_CNT_W-1:0] edge_count;
  logic               count_valid;
  logic [0:0]         dbg_state;

  edge_binarizer #(.IMG_WIDTH(AW), .IMG_HEIGHT(AH)) dut_a (
    .clk(clk), .rst(rst), .threshold(threshold),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
    .y_sof(y_sof), .y_eol(y_eol), .y_eof(y_eof),
    .edge_count(edge_count), .count_valid(count_valid), .dbg_state(dbg_state)
  );

  // ---------------- DUT B (40x30) ----------------
  logic [7:0]         b_threshold = 8'h00;
  logic               b_x_valid = 1'b0;
  logic               b_x_ready;
  logic [7:0]         b_x_data = 8'h00;
  logic               b_y_valid;
  logic               b_y_ready = 1'b1;
  logic [7:0]         b_y_data;
  logic               b_y_sof, b_y_eol, b_y_eof;
  logic [B_CNT_W-1:0] b_edge_count;
  logic               b_count_valid;
  logic [0:0]         b_dbg_state;

  edge_binarizer #(.IMG_WIDTH(BW), .IMG_HEIGHT(BH)) dut_b (
    .clk(clk), .rst(rst), .threshold(b_threshold),
    .x_valid(b_x_valid), .x_ready(b_x_ready), .x_data(b_x_data),
    .y_valid(b_y_valid), .y_ready(b_y_ready), .y_data(b_y_data),
    .y_sof(b_y_sof), .y_eol(b_y_eol), .y_eof(b_y_eof),
    .edge_count(b_edge_count), .count_valid(b_count_valid), .dbg_state(b_dbg_state)
  );

  logic [10:0] a_beat, b_beat;
  assign a_beat = {y_sof, y_eol, y_eof, y_data};
  assign b_beat = {b_y_sof, b_y_eol, b_y_eof, b_y_data};

  // ---------------- scoreboard state ----------------
  logic [10:0] exp_q[$], got_q[$], b_exp_q[$], b_got_q[$];
  int          exp_cnt_q[$], cnt_q[$], cnt_cyc_q[$], b_exp_cnt_q[$], b_cnt_q[$];
  logic [7:0]  frame_px[$];
  vec_t        tbl[12];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          ready_mode = 0;  // 0: always ready, 1: random, 2: driven by main
  int          cyc = 0;
  int          in_total = 0;
  int          out_total = 0;
  bit          settled = 1'b0;
  bit          prev_stall = 1'b0;
  bit          abort = 1'b0;
  logic [10:0] prev_beat = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected beat straight from the pixel rules: {sof, eol, eof, data}.
  function automatic logic [10:0] model_beat(input int idx, input int w, input int h,
                                             input logic [7:0] pix, input logic [7:0] thr);
    int r, c;
    bit border;
    logic [7:0] d;
    r = idx / w;
    c = idx % w;
    border = (r == 0) || (r == h - 1) || (c == 0) || (c == w - 1);
    d = (!border && pix >= thr) ? 8'hFF : 8'h00;
    return {idx == 0, c == w - 1, idx == w * h - 1, d};
  endfunction

  // ---------------- y_ready driver + output monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (ready_mode == 0) y_ready = 1'b1;
      else if (ready_mode == 1) y_ready = ($urandom_range(0, 1) == 1);
      b_y_ready = ($urandom_range(0, 2) != 0);
      #2;
      cyc++;
      if (rst) begin
        got_q.delete(); cnt_q.delete(); cnt_cyc_q.delete();
        b_got_q.delete(); b_cnt_q.delete();
        in_total = 0; out_total = 0; settled = 1'b0; prev_stall = 1'b0;
      end else begin
        if (settled) check("x_ready_vs_fill", 32'(x_ready), 32'((in_total - out_total) != 2));
        if (prev_stall) check("y_hold_while_stalled", 32'({y_valid, a_beat}), 32'({1'b1, prev_beat}));
        if (x_valid && x_ready) in_total++;
        if (y_valid && y_ready) begin
          got_q.push_back(a_beat);
          out_total++;
        end
        if (count_valid) begin
          cnt_q.push_back(int'(edge_count));
          cnt_cyc_q.push_back(cyc);
        end
        prev_stall = y_valid && !y_ready;
        prev_beat  = a_beat;
        settled    = 1'b1;
        if (b_y_valid && b_y_ready) b_got_q.push_back(b_beat);
        if (b_count_valid) b_cnt_q.push_back(int'(b_edge_count));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_pixel(input bit sel_b, input logic [7:0] d);
    int n = 0;
    if (abort) return;
    if (sel_b) begin b_x_valid = 1'b1; b_x_data = d; end
    else begin x_valid = 1'b1; x_data = d; end
    while (((sel_b ? b_x_ready : x_ready) == 1'b0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if ((sel_b ? b_x_ready : x_ready) == 1'b0) begin
      n_cmp++; n_bad++; abort = 1'b1;
      $display("FAIL x_ready_timeout: input not accepted within 200 cycles");
      return;
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input bit sel_b, input logic [7:0] thr_sof, input int chg_idx,
                            input logic [7:0] thr_after);
    logic [7:0] t;
    for (int i = 0; i < frame_px.size(); i++) begin
      t = (chg_idx >= 0 && i >= chg_idx) ? thr_after : thr_sof;
      if (sel_b) b_threshold = t; else threshold = t;
      send_pixel(sel_b, frame_px[i]);
    end
  endtask

  task automatic queue_frame_exp(input bit sel_b, input logic [7:0] thr);
    int w, h, cnt;
    logic [10:0] e;
    w = sel_b ? BW : AW;
    h = sel_b ? BH : AH;
    cnt = 0;
    for (int i = 0; i < w * h; i++) begin
      e = model_beat(i, w, h, frame_px[i], thr);
      if (e[7:0] == 8'hFF) cnt++;
      if (sel_b) b_exp_q.push_back(e); else exp_q.push_back(e);
    end
    if (sel_b) b_exp_cnt_q.push_back(cnt); else exp_cnt_q.push_back(cnt);
  endtask

  task automatic random_frame(input bit sel_b);
    int n;
    n = sel_b ? BW * BH : AW * AH;
    frame_px.delete();
    for (int i = 0; i < n; i++)
      frame_px.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255)));
  endtask

  task automatic drain_compare(input bit sel_b, input string name);
    int k = 0;
    logic [31:0] g;
    while (k < 3000 && (sel_b ? (b_got_q.size() < b_exp_q.size()) : (got_q.size() < exp_q.size()))) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    if (!sel_b) begin
      while (exp_q.size() > 0) begin
        g = (got_q.size() > 0) ? 32'(got_q.pop_front()) : 32'hDEAD;
        check({name, "_beat"}, g, 32'(exp_q.pop_front()));
      end
      check({name, "_extra_beats"}, 32'(got_q.size()), 32'd0);
      while (exp_cnt_q.size() > 0) begin
        g = (cnt_q.size() > 0) ? 32'(cnt_q.pop_front()) : 32'hDEAD;
        check({name, "_edge_count"}, g, 32'(exp_cnt_q.pop_front()));
      end
      check({name, "_extra_count_pulses"}, 32'(cnt_q.size()), 32'd0);
    end else begin
      while (b_exp_q.size() > 0) begin
        g = (b_got_q.size() > 0) ? 32'(b_got_q.pop_front()) : 32'hDEAD;
        check({name, "_beat"}, g, 32'(b_exp_q.pop_front()));
      end
      check({name, "_extra_beats"}, 32'(b_got_q.size()), 32'd0);
      while (b_exp_cnt_q.size() > 0) begin
        g = (b_cnt_q.size() > 0) ? 32'(b_cnt_q.pop_front()) : 32'hDEAD;
        check({name, "_edge_count"}, g, 32'(b_exp_cnt_q.pop_front()));
      end
      check({name, "_extra_count_pulses"}, 32'(b_cnt_q.size()), 32'd0);
    end
  endtask

  // Plays the 12-pixel table frame and expects exactly the table outputs.
  task automatic run_table(input string name, input int mode);
    int cnt = 0;
    ready_mode = mode;
    threshold = 8'h40;
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back({tbl[i].exp_sof, tbl[i].exp_eol, tbl[i].exp_eof, tbl[i].exp_data});
      if (tbl[i].exp_data == 8'hFF) cnt++;
    end
    exp_cnt_q.push_back(cnt);
    for (int i = 0; i < 12; i++) begin
      send_pixel(1'b0, tbl[i].pix);
      if (i == 3) check({name, "_state_active"}, 32'(dbg_state), 32'd1);
    end
    x_valid = 1'b0;
    drain_compare(1'b0, name);
    check({name, "_state_idle"}, 32'(dbg_state), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int gap;
    for (int i = 0; i < 12; i++) begin
      tbl[i].pix      = 8'h80;
      tbl[i].exp_data = (i == 5 || i == 6) ? 8'hFF : 8'h00;
      tbl[i].exp_sof  = (i == 0);
      tbl[i].exp_eol  = (i == 3 || i == 7 || i == 11);
      tbl[i].exp_eof  = (i == 11);
    end

    repeat (3) @(negedge clk);
    check("rst_x_ready", 32'(x_ready), 32'd0);
    check("rst_y_valid", 32'(y_valid), 32'd0);
    check("rst_y_beat", 32'(a_beat), 32'd0);
    check("rst_edge_count", 32'(edge_count), 32'd0);
    check("rst_count_valid", 32'(count_valid), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("x_ready_after_release", 32'(x_ready), 32'd1);

    // Table frame with free-flowing output, then with random back-pressure.
    run_table("s1", 0);
    run_table("s2", 1);

    // Mid-frame threshold change is ignored until the next sof.
    ready_mode = 0;
    frame_px.delete();
    for (int i = 0; i < 12; i++) frame_px.push_back(8'h80);
    queue_frame_exp(1'b0, 8'h40);
    send_frame(1'b0, 8'h40, 5, 8'hFF);
    x_valid = 1'b0;
    drain_compare(1'b0, "s3_frame1");
    queue_frame_exp(1'b0, 8'hFF);
    send_frame(1'b0, 8'hFF, -1, 8'hFF);
    x_valid = 1'b0;
    drain_compare(1'b0, "s3_frame2");

    // Back-to-back frames with no idle cycle between them.
    cnt_cyc_q.delete();
    frame_px.delete();
    for (int i = 0; i < 12; i++) frame_px.push_back(8'hFF);
    queue_frame_exp(1'b0, 8'h10);
    send_frame(1'b0, 8'h10, -1, 8'h10);
    frame_px.delete();
    for (int i = 0; i < 12; i++) frame_px.push_back(8'h10);
    queue_frame_exp(1'b0, 8'h10);
    send_frame(1'b0, 8'h10, -1, 8'h10);
    x_valid = 1'b0;
    repeat (4) @(negedge clk);
    gap = (cnt_cyc_q.size() >= 2) ? (cnt_cyc_q[1] - cnt_cyc_q[0]) : -1;
    check("s4_pulse_gap", 32'(gap), 32'd12);
    drain_compare(1'b0, "s4");

    // Async reset mid-frame with one beat parked in the buffer.
    ready_mode = 2;
    y_ready = 1'b1;
    threshold = 8'h40;
    for (int i = 0; i < 5; i++) send_pixel(1'b0, 8'h80);
    x_valid = 1'b0;
    repeat (2) @(negedge clk);
    y_ready = 1'b0;
    send_pixel(1'b0, 8'h80);
    x_valid = 1'b0;
    check("s5_beat_buffered", 32'(y_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("s5_rst_y_valid", 32'(y_valid), 32'd0);
    check("s5_rst_edge_count", 32'(edge_count), 32'd0);
    check("s5_rst_x_ready", 32'(x_ready), 32'd0);
    check("s5_rst_state", 32'(dbg_state), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_table("s5_after_rst", 0);

    // Random frames on the small image, threshold corners 0x00 and 0xFF included.
    for (int f = 0; f < 6; f++) begin
      logic [7:0] thr;
      thr = (f == 0) ? 8'h00 : (f == 1) ? 8'hFF : 8'($urandom_range(0, 255));
      random_frame(1'b0);
      queue_frame_exp(1'b0, thr);
      send_frame(1'b0, thr, int'($urandom_range(1, 11)), 8'($urandom_range(0, 255)));
    end
    ready_mode = 1;
    x_valid = 1'b0;
    drain_compare(1'b0, "s7_random");

    // Larger image, random data/threshold, random back-pressure.
    for (int f = 0; f < 2; f++) begin
      logic [7:0] thr;
      thr = 8'($urandom_range(0, 255));
      random_frame(1'b1);
      queue_frame_exp(1'b1, thr);
      send_frame(1'b1, thr, -1, thr);
    end
    b_x_valid = 1'b0;
    drain_compare(1'b1, "s6_large");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: bench did not complete within 50000 cycles");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
